// File: rtl/gumnut_bus_pkg.sv
// gumnut_bus_pkg: shared bus widths, wait-count width and responder state encoding
package gumnut_bus_pkg;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = 3;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
endpackage

// File: rtl/gumnut_data_mem_ram.sv
// dmem_ram: DEPTH x 8 storage with synchronous write and registered read, no reset
//   clk_i        clock
//   we_i, re_i   write / read enables (mutually exclusive)
//   adr_i        word address, always < DEPTH when an enable is high
//   dat_i        write data
//   dat_o        read data register, changes only on a read
module dmem_ram
  import gumnut_bus_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;
  logic [IW-1:0] idx;
  assign idx = adr_i[IW-1:0];
  assign dat_o = rd_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx] <= dat_i;
    if (re_i) rd_q <= mem_q[idx];
  end
endmodule

// File: rtl/gumnut_data_mem.sv
// gumnut_data_mem: Wishbone-style data memory responder with configurable wait states
//   clk_i, rst_i  clock, asynchronous active-low reset
//   cyc_i, stb_i  bus cycle / strobe; we_i selects write
//   adr_i, dat_i  word address and write data
//   dat_o         read data, valid while ack_o is high
//   ack_o, err_o  one-cycle completion / error pulses
//   GUMNUT_DMEM_ERR_EN  when defined, addresses >= DEPTH answer with err_o;
//                       otherwise addresses wrap modulo DEPTH and err_o is 0
module gumnut_data_mem
  import gumnut_bus_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  output logic          ack_o,
  output logic          err_o
);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] adr_q, a_in, a_d;
  logic [DW-1:0] dat_q, d_d, ram_q;
  logic          we_q, w_d, ack_q, vld_q, go, bad;
`ifdef GUMNUT_DMEM_ERR_EN
  logic err_q;
  assign a_in  = adr_i;
  assign bad   = 32'(a_d) >= DEPTH;
  assign err_o = err_q;
`else
  assign a_in  = AW'(32'(adr_i) % DEPTH);
  assign bad   = 1'b0;
  assign err_o = 1'b0;
`endif
  // With zero wait states the access happens on the capture edge, so the RAM sees live inputs in IDLE
  assign a_d = state_q == IDLE ? a_in : adr_q;
  assign d_d = state_q == IDLE ? dat_i : dat_q;
  assign w_d = state_q == IDLE ? we_i : we_q;
  // go marks the edge that enters ACK
  assign go = rst_i & (state_q == IDLE ? cyc_i & stb_i & (WAIT_STATES == 0)
                                       : (state_q == WAIT) & cyc_i & (cnt_q == CW'(1)));
  assign ack_o = ack_q;
  // The RAM read register has no reset, so dat_o reads 0 until the first read after reset
  assign dat_o = vld_q ? ram_q : '0;
  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i(clk_i),
    .we_i (go & ~bad & w_d),
    .re_i (go & ~bad & ~w_d),
    .adr_i(a_d),
    .dat_i(d_d),
    .dat_o(ram_q)
  );
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef GUMNUT_DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= go & ~bad;
`ifdef GUMNUT_DMEM_ERR_EN
      err_q <= go & bad;
`endif
      if (go & ~bad & ~w_d) vld_q <= 1'b1;
      case (state_q)
        IDLE: if (cyc_i & stb_i) begin
          adr_q   <= a_in;
          dat_q   <= dat_i;
          we_q    <= we_i;
          cnt_q   <= CW'(WAIT_STATES);
          state_q <= WAIT_STATES == 0 ? ACK : WAIT;
        end
        WAIT: begin
          cnt_q   <= cyc_i ? cnt_q - 1'b1 : '0;
          state_q <= !cyc_i ? IDLE : go ? ACK : WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gumnut_data_mem.md
GUMNUT_DATA_MEM -- requirements
Module: gumnut_data_mem

Interface
REQ-001 Parameter DEPTH, default 256, number of 8-bit words; legal values are 1 to 256.
REQ-002 Parameter WAIT_STATES, default 0, number of extra cycles before ack; legal values are 0 to 7.
REQ-003 Port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_i, input, 1 bit: reset; one clock; reset is asynchronous and active-low.
REQ-005 Port cyc_i, input, 1 bit: bus cycle in progress.
REQ-006 Port stb_i, input, 1 bit: transfer strobe.
REQ-007 Port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port adr_i, input, 8 bits: word address.
REQ-009 Port dat_i, input, 8 bits: write data.
REQ-010 Port dat_o, output, 8 bits: read data; valid only while ack_o = 1.
REQ-011 Port ack_o, output, 1 bit: transfer complete, one-cycle pulse.
REQ-012 Port err_o, output, 1 bit: transfer error, one-cycle pulse; tied to 0 unless GUMNUT_DMEM_ERR_EN is defined.

Function
REQ-013 The block SHALL implement a responder FSM with states IDLE, WAIT and ACK.
REQ-014 In IDLE, on a cycle with cyc_i & stb_i = 1, the block SHALL capture adr_i, we_i and dat_i and load wait_cnt = WAIT_STATES.
- Next state is WAIT if WAIT_STATES > 0, otherwise ACK.
REQ-015 In WAIT, the block SHALL decrement wait_cnt each cycle and go to ACK when wait_cnt = 1.
REQ-016 In WAIT, cyc_i = 0 SHALL abort the transfer: return to IDLE with no memory write and no ack_o.
REQ-017 In ACK, the block SHALL drive ack_o = 1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: ack_o SHALL be high in the cycle exactly WAIT_STATES+1 cycles after the request cycle.
REQ-019 Back-to-back requests: if stb_i is still high in the cycle after ACK, it SHALL be treated as a new request; minimum spacing between requests is WAIT_STATES+2 cycles.
REQ-020 Write: mem[captured adr] SHALL be updated with the captured dat_i on the clock edge entering ACK.
REQ-021 Read: dat_o SHALL be loaded with mem[captured adr] on the clock edge entering ACK.
- dat_o holds its value otherwise.
- A read of an address written in an earlier transfer returns the new value.
REQ-022 Inputs sampled outside IDLE SHALL be ignored, apart from the abort condition in WAIT.
REQ-023 ack_o and err_o SHALL never be asserted in the same cycle.

Reset
REQ-024 While rst_i = 0, the block SHALL be held with state = IDLE, wait_cnt = 0, ack_o = 0, err_o = 0 and dat_o = 8'h00.
REQ-025 Reset asserted mid-transfer SHALL cancel the transfer with no write and no ack_o.
- The first request is accepted on the first rising edge after rst_i deasserts.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-027 With GUMNUT_DMEM_ERR_EN defined, a captured address >= DEPTH SHALL produce err_o instead of ack_o, in the same cycle ack_o would have appeared.
- No write is performed and dat_o is left unchanged.
REQ-028 Without GUMNUT_DMEM_ERR_EN, err_o SHALL be tied to 0 and adr_i SHALL be taken modulo DEPTH.

Structure
REQ-029 The state enum, the 3-bit wait-count width and the bus data/address width constants SHALL live in the shared package gumnut_bus_pkg.
REQ-030 Storage SHALL be a sub-module dmem_ram: synchronous write, registered read, no reset.
- The FSM, address/data capture and error check stay in gumnut_data_mem.

Verification
REQ-031 WAIT_STATES=0: write adr 8'h10 data 8'hA5, then read 8'h10 -> each ack_o one cycle after its request; the read returns dat_o = 8'hA5.
REQ-032 WAIT_STATES=3: read request at cycle N -> ack_o high only in cycle N+4; no ack_o in cycles N+1 to N+3.
REQ-033 WAIT_STATES=3: write 8'h3C to 8'h20, drop cyc_i at N+2; then read 8'h20 -> no ack_o for the aborted write; the read returns the prior contents.
REQ-034 stb_i held high continuously with WAIT_STATES=0 -> ack_o pulses every 2nd cycle; each pulse returns the correct data.
REQ-035 rst_i pulled low during WAIT -> ack_o, err_o and dat_o read 0 immediately; no write occurs; the next request completes normally.
REQ-036 GUMNUT_DMEM_ERR_EN defined, DEPTH=128, access to 8'h80 -> err_o pulses once, ack_o stays 0, and mem[8'h00] is unchanged.
